// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the 800x600@60 VGA timing generator.
//   - H/V visible, porch, sync and total counts (12-bit unsigned)
//   - derived sync window bounds and the merged-bus width
//   - flags_t: the registered per-pixel flags that travel with the counters
//   - bar_colour(): colour-bar lookup, present only when
//     VGA_TIMING_TEST_PATTERN_EN is defined
// The VGA bus-width macro is also defined here (guarded) so every file that
// imports the package sees the same value.
// -----------------------------------------------------------------------------
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 40
`endif

package vga_timing_pkg;

    localparam int CNT_W     = 12;
    localparam int VGA_BUS_W = `VGA_BUS_SIZE;

    // Horizontal timing, in pixels
    localparam logic [CNT_W-1:0] H_VISIBLE = 12'd800;
    localparam logic [CNT_W-1:0] H_FRONT   = 12'd40;
    localparam logic [CNT_W-1:0] H_SYNC    = 12'd128;
    localparam logic [CNT_W-1:0] H_BACK    = 12'd88;
    localparam logic [CNT_W-1:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam logic [CNT_W-1:0] V_VISIBLE = 12'd600;
    localparam logic [CNT_W-1:0] V_FRONT   = 12'd1;
    localparam logic [CNT_W-1:0] V_SYNC    = 12'd4;
    localparam logic [CNT_W-1:0] V_BACK    = 12'd23;
    localparam logic [CNT_W-1:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Inclusive sync windows
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = H_VISIBLE + H_FRONT;
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 12'd1;
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = V_VISIBLE + V_FRONT;
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 12'd1;

    typedef struct packed {
        logic        hs;
        logic        hblnk;
        logic        vs;
        logic        vblnk;
        logic [11:0] rgb;
        logic        frame_start;
        logic        line_start;
    } flags_t;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_WIDTH = 100;

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'hFF0;
            3'd2:    return 12'h0FF;
            3'd3:    return 12'h0F0;
            3'd4:    return 12'hF0F;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction
`endif

endpackage

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Output bundle of the VGA timing generator.
//   vga_out     : merged bus {hcount, hs, hblnk, vcount, vs, vblnk, rgb}, MSB first
//   frame_start : one-cycle pulse at pixel (0,0)
//   line_start  : one-cycle pulse at hcount 0
// Modports: master (the generator drives), slave (a consumer reads).
// -----------------------------------------------------------------------------
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic [VGA_BUS_W-1:0] vga_out;
    logic                 frame_start;
    logic                 line_start;

    modport master (output vga_out, output frame_start, output line_start);
    modport slave  (input  vga_out, input  frame_start, input  line_start);
endinterface

// File: rtl/vga_counter.sv
// -----------------------------------------------------------------------------
// vga_counter
// Wrapping up-counter, 0 .. TOTAL-1, advancing only while en is high.
//   clk, rst_n : clock, asynchronous active-low reset (count resets to 0)
//   en         : advance this cycle
//   count      : registered count
//   count_next : value count takes on the next clock edge
//   wrap       : en is high and count is at TOTAL-1 (next value is 0)
// count_next is exported so the parent can register flags that line up with
// count in the same cycle, without a pipeline skew.
// -----------------------------------------------------------------------------
module vga_counter #(
    parameter int           W     = 12,
    parameter logic [W-1:0] TOTAL = W'(1056)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = TOTAL - W'(1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = en && (count_q == LAST);
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge values, regardless of the order the processes are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// 800x600@60 VGA timing generator (40 MHz pixel clock).
//   pclk : pixel clock, rising edge
//   rst  : asynchronous active-low reset; holds the bus at pixel (0,0)
//   vga  : vga_timing_if.master -- merged VGA bus, frame_start, line_start
// Parameter RGB_BLANK is the colour driven while blanking or with no pattern.
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN adds eight 100-px vertical
// colour bars in the visible area; without it rgb is always RGB_BLANK.
//
// The flags are registered from the counters' next values, so flags and
// counters change on the same edge and always describe the same pixel.
// -----------------------------------------------------------------------------
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter logic [11:0] RGB_BLANK = 12'h000
) (
    input  logic         pclk,
    input  logic         rst,
    vga_timing_if.master vga
);

    logic [CNT_W-1:0] h_q, h_next;
    logic [CNT_W-1:0] v_q, v_next;
    logic             h_wrap, v_wrap;

    flags_t flags_q, flags_d;

    vga_counter #(.W(CNT_W), .TOTAL(H_TOTAL)) u_h_cnt (
        .clk        (pclk),
        .rst_n      (rst),
        .en         (1'b1),
        .count      (h_q),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_counter #(.W(CNT_W), .TOTAL(V_TOTAL)) u_v_cnt (
        .clk        (pclk),
        .rst_n      (rst),
        .en         (h_wrap),
        .count      (v_q),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    // NOTE: every field gets a value before any condition is tested, so no
    // path through this block can leave a field unassigned and infer a latch.
    always_comb begin
        flags_d       = '0;
        flags_d.hblnk = (h_next >= H_VISIBLE);
        flags_d.vblnk = (v_next >= V_VISIBLE);
        flags_d.hs    = (h_next >= H_SYNC_FIRST) && (h_next <= H_SYNC_LAST);
        flags_d.vs    = (v_next >= V_SYNC_FIRST) && (v_next <= V_SYNC_LAST);
        flags_d.rgb   = RGB_BLANK;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        if (!flags_d.hblnk && !flags_d.vblnk) begin
            flags_d.rgb = bar_colour(3'(h_next / CNT_W'(BAR_WIDTH)));
        end
`endif
        // Next position is column 0 exactly when H wraps, and (0,0) exactly
        // when V wraps (V only advances on an H wrap).
        flags_d.line_start  = h_wrap;
        flags_d.frame_start = v_wrap;
    end

    // Reset values are the legal flags for pixel (0,0).
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            flags_q <= '{hs: 1'b0, hblnk: 1'b0, vs: 1'b0, vblnk: 1'b0,
                         rgb: RGB_BLANK, frame_start: 1'b1, line_start: 1'b1};
        end else begin
            flags_q <= flags_d;
        end
    end

    assign vga.vga_out     = {h_q, flags_q.hs, flags_q.hblnk,
                              v_q, flags_q.vs, flags_q.vblnk, flags_q.rgb};
    assign vga.frame_start = flags_q.frame_start;
    assign vga.line_start  = flags_q.line_start;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Self-checking bench for vga_timing: directed position/flag vectors from a
// table plus hand-written sequences for reset, line sweep and frame period.
// Honours VGA_TIMING_TEST_PATTERN_EN for the expected rgb values.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    localparam logic [11:0] TB_BLANK = 12'h5A5;

    typedef struct {
        int          h;
        int          v;
        bit          hs;
        bit          hb;
        bit          vs;
        bit          vb;
        bit          fs;
        bit          ls;
        logic [11:0] pat;  // rgb expected when the test pattern is built in
    } vec_t;

    logic pclk;
    logic rst;

    vga_timing_if vga_bus ();

    vga_timing #(.RGB_BLANK(TB_BLANK)) dut (
        .pclk (pclk),
        .rst  (rst),
        .vga  (vga_bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int vs_lines = 0;
    int vs_first = -1;

    logic [11:0] cur_h, cur_v, cur_rgb;
    logic        cur_hs, cur_hb, cur_vs, cur_vb, cur_fs, cur_ls;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t mk(input int h, input int v, input bit hs, input bit hb,
                                input bit vs, input bit vb, input bit fs, input bit ls,
                                input logic [11:0] pat);
        vec_t e;
        e.h = h; e.v = v; e.hs = hs; e.hb = hb; e.vs = vs; e.vb = vb;
        e.fs = fs; e.ls = ls; e.pat = pat;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic sample();
        logic [39:0] b;
        b       = vga_bus.vga_out;
        cur_h   = b[39:28];
        cur_hs  = b[27];
        cur_hb  = b[26];
        cur_v   = b[25:14];
        cur_vs  = b[13];
        cur_vb  = b[12];
        cur_rgb = b[11:0];
        cur_fs  = vga_bus.frame_start;
        cur_ls  = vga_bus.line_start;
    endtask

    task automatic step();
        @(negedge pclk);
        cyc++;
        sample();
        if (cur_h == 12'd0 && cur_vs) begin
            if (vs_lines == 0) vs_first = int'(cur_v);
            vs_lines++;
        end
    endtask

    task automatic goto(input int h, input int v);
        int budget = 700000;
        while (!(int'(cur_h) == h && int'(cur_v) == v) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL goto(%0d,%0d): timed out at (%0d,%0d)", h, v, cur_h, cur_v);
        end
    endtask

    task automatic check_fields(input string tag, input vec_t e);
        string p;
        logic [11:0] exp_rgb;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        exp_rgb = e.pat;
`else
        exp_rgb = TB_BLANK;
`endif
        p = $sformatf("%s(%0d,%0d)", tag, e.h, e.v);
        check({p, ".hcount"}, int'(cur_h), e.h);
        check({p, ".vcount"}, int'(cur_v), e.v);
        check({p, ".hs"}, int'(cur_hs), int'(e.hs));
        check({p, ".hblnk"}, int'(cur_hb), int'(e.hb));
        check({p, ".vs"}, int'(cur_vs), int'(e.vs));
        check({p, ".vblnk"}, int'(cur_vb), int'(e.vb));
        check({p, ".rgb"}, int'(cur_rgb), int'(exp_rgb));
        check({p, ".frame_start"}, int'(cur_fs), int'(e.fs));
        check({p, ".line_start"}, int'(cur_ls), int'(e.ls));
    endtask

    initial begin
        int   hs_cnt;
        int   hs_first;
        int   hb_first;
        logic hs_968;

        // Early part of the frame: bars on line 20, H blanking and H sync.
        //                 h    v  hs hb vs vb fs ls pat
        tbl_a.push_back(mk(0,   12, 0, 0, 0, 0, 0, 1, 12'hFFF));
        tbl_a.push_back(mk(99,  20, 0, 0, 0, 0, 0, 0, 12'hFFF));
        tbl_a.push_back(mk(100, 20, 0, 0, 0, 0, 0, 0, 12'hFF0));
        tbl_a.push_back(mk(150, 20, 0, 0, 0, 0, 0, 0, 12'hFF0));
        tbl_a.push_back(mk(250, 20, 0, 0, 0, 0, 0, 0, 12'h0FF));
        tbl_a.push_back(mk(350, 20, 0, 0, 0, 0, 0, 0, 12'h0F0));
        tbl_a.push_back(mk(450, 20, 0, 0, 0, 0, 0, 0, 12'hF0F));
        tbl_a.push_back(mk(550, 20, 0, 0, 0, 0, 0, 0, 12'hF00));
        tbl_a.push_back(mk(650, 20, 0, 0, 0, 0, 0, 0, 12'h00F));
        tbl_a.push_back(mk(799, 20, 0, 0, 0, 0, 0, 0, 12'h000));
        tbl_a.push_back(mk(800, 20, 0, 1, 0, 0, 0, 0, TB_BLANK));
        tbl_a.push_back(mk(850, 20, 1, 1, 0, 0, 0, 0, TB_BLANK));
        tbl_a.push_back(mk(968, 20, 0, 1, 0, 0, 0, 0, TB_BLANK));
        tbl_a.push_back(mk(400, 300, 0, 0, 0, 0, 0, 0, 12'hF0F));

        // End of frame after the mid-frame reset: V blanking and V sync.
        tbl_b.push_back(mk(1055, 599, 0, 1, 0, 0, 0, 0, TB_BLANK));
        tbl_b.push_back(mk(0,    600, 0, 0, 0, 1, 0, 1, TB_BLANK));
        tbl_b.push_back(mk(0,    601, 0, 0, 1, 1, 0, 1, TB_BLANK));
        tbl_b.push_back(mk(500,  604, 0, 0, 1, 1, 0, 0, TB_BLANK));
        tbl_b.push_back(mk(0,    605, 0, 0, 0, 1, 0, 1, TB_BLANK));
        tbl_b.push_back(mk(1055, 627, 0, 1, 0, 1, 0, 0, TB_BLANK));

        // Power-on reset held for 5 cycles.
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (5) begin
            step();
            check_fields("reset", mk(0, 0, 0, 0, 0, 0, 1, 1, TB_BLANK));
        end
        rst = 1'b1;
        step();
        check_fields("release", mk(1, 0, 0, 0, 0, 0, 0, 0, 12'hFFF));

        // Line wrap mid-frame.
        goto(1055, 10);
        check_fields("pre_wrap", mk(1055, 10, 0, 1, 0, 0, 0, 0, TB_BLANK));
        step();
        check_fields("line_wrap", mk(0, 11, 0, 0, 0, 0, 0, 1, 12'hFFF));

        // Sweep line 11 for the H blanking edge and the H sync window.
        hs_cnt   = 0;
        hs_first = -1;
        hb_first = -1;
        hs_968   = 1'b1;
        for (int i = 1; i < 1056; i++) begin
            step();
            if (cur_hs) begin
                if (hs_first < 0) hs_first = int'(cur_h);
                hs_cnt++;
            end
            if (cur_hb && hb_first < 0) hb_first = int'(cur_h);
            if (cur_h == 12'd968) hs_968 = cur_hs;
        end
        check("hblnk_rise_h", hb_first, 800);
        check("hs_first_h", hs_first, 840);
        check("hs_width", hs_cnt, 128);
        check("hs_at_968", int'(hs_968), 0);

        for (int i = 0; i < tbl_a.size(); i++) begin
            goto(tbl_a[i].h, tbl_a[i].v);
            check_fields("tbl_a", tbl_a[i]);
        end

        // Asynchronous reset at (400,300): takes effect without a clock edge.
        rst = 1'b0;
        #1;
        sample();
        check_fields("async_rst", mk(0, 0, 0, 0, 0, 0, 1, 1, TB_BLANK));
        repeat (3) begin
            step();
            check_fields("rst_hold", mk(0, 0, 0, 0, 0, 0, 1, 1, TB_BLANK));
        end
        cyc      = 0;
        vs_lines = 0;
        vs_first = -1;
        rst = 1'b1;
        step();
        check_fields("re_release", mk(1, 0, 0, 0, 0, 0, 0, 0, 12'hFFF));

        for (int i = 0; i < tbl_b.size(); i++) begin
            goto(tbl_b[i].h, tbl_b[i].v);
            check_fields("tbl_b", tbl_b[i]);
        end

        // Frame wrap and frame period measured from the restarted frame.
        step();
        check_fields("frame_wrap", mk(0, 0, 0, 0, 0, 0, 1, 1, 12'hFFF));
        check("frame_period", cyc, 663168);
        check("vs_lines", vs_lines, 4);
        check("vs_first_v", vs_first, 601);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
